// File: rtl/text_write_scheduler_if.sv
// Bus bundle between the character source and the text RAM write scheduler.
// The slave modport is the scheduler's view; the master modport is the view of
// whatever drives characters in and observes the write port and the cursor.
interface text_write_scheduler_if;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [3:0] wr_row;
  logic [5:0] wr_col;
  logic [7:0] wr_char;
  logic [3:0] cur_row;
  logic [5:0] cur_col;
  logic       busy;

  modport slave (
    input  in_char,
    input  in_valid,
    output in_ready,
    output wr_en,
    output wr_row,
    output wr_col,
    output wr_char,
    output cur_row,
    output cur_col,
    output busy
  );

  modport master (
    output in_char,
    output in_valid,
    input  in_ready,
    input  wr_en,
    input  wr_row,
    input  wr_col,
    input  wr_char,
    input  cur_row,
    input  cur_col,
    input  busy
  );
endinterface

// File: rtl/text_write_scheduler.sv
// Text RAM write scheduler: sole owner of the character-cell RAM write port.
// Accepts bytes over valid/ready, tracks the cursor, interprets LF/CR/BS/FF,
// and generates character, erase and blank-fill writes (one per cycle).
//
// Optional feature macro: LINE_CLEAR_EN
//   defined   -> entering a new row (column wrap or LF) blanks that row
//   undefined -> row changes only move the cursor
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a byte; printable/BS writes issue from here
// CLEAR_ALL | blanking the whole screen row-major (after reset or FF)
// CLEAR_ROW | blanking the cursor row, col 0..COLS-1 (LINE_CLEAR_EN only)
module text_write_scheduler #(
  parameter int         ROWS  = 16,
  parameter int         COLS  = 64,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset,
  text_write_scheduler_if.slave  bus
);

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [5:0] LAST_COL = 6'(COLS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ALL = 2'd1
`ifdef LINE_CLEAR_EN
    ,
    CLEAR_ROW = 2'd2
`endif
  } state_t;

  state_t     state, state_n;
  logic [3:0] fill_row, fill_row_n;
  logic [5:0] fill_col, fill_col_n;

  logic       wr_en_q,   wr_en_n;
  logic [3:0] wr_row_q,  wr_row_n;
  logic [5:0] wr_col_q,  wr_col_n;
  logic [7:0] wr_char_q, wr_char_n;
  logic [3:0] cur_row_q, cur_row_n;
  logic [5:0] cur_col_q, cur_col_n;
  logic       busy_q,    busy_n;
  logic       ready_q,   ready_n;

  logic       accept;
  logic       printable;
  logic [3:0] row_next;

  // State and fill counter; reset (even mid-sequence) restarts the full clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR_ALL;
      fill_row <= '0;
      fill_col <= '0;
    end else begin
      state    <= state_n;
      fill_row <= fill_row_n;
      fill_col <= fill_col_n;
    end
  end

  // Registered outputs: write port, cursor and handshake status.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_char_q <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      busy_q    <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_n;
      wr_row_q  <= wr_row_n;
      wr_col_q  <= wr_col_n;
      wr_char_q <= wr_char_n;
      cur_row_q <= cur_row_n;
      cur_col_q <= cur_col_n;
      busy_q    <= busy_n;
      ready_q   <= ready_n;
    end
  end

  // Next-state, byte interpretation and next values of the registered outputs.
  always_comb begin
    state_n    = state;
    fill_row_n = fill_row;
    fill_col_n = fill_col;
    wr_en_n    = 1'b0;
    wr_row_n   = wr_row_q;
    wr_col_n   = wr_col_q;
    wr_char_n  = wr_char_q;
    cur_row_n  = cur_row_q;
    cur_col_n  = cur_col_q;

    // ready_q is only ever high in IDLE, so it doubles as the accept gate.
    accept    = bus.in_valid && ready_q;
    printable = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);
    row_next  = (cur_row_q == LAST_ROW) ? 4'd0 : cur_row_q + 4'd1;

    case (state)
      IDLE: begin
        if (accept) begin
          if (printable) begin
            wr_en_n   = 1'b1;
            wr_row_n  = cur_row_q;
            wr_col_n  = cur_col_q;
            wr_char_n = bus.in_char;
            if (cur_col_q == LAST_COL) begin
              cur_col_n = '0;
              cur_row_n = row_next;
`ifdef LINE_CLEAR_EN
              state_n    = CLEAR_ROW;
              fill_col_n = '0;
`endif
            end else begin
              cur_col_n = cur_col_q + 6'd1;
            end
          end else begin
            case (bus.in_char)
              CH_LF: begin
                cur_col_n = '0;
                cur_row_n = row_next;
`ifdef LINE_CLEAR_EN
                state_n    = CLEAR_ROW;
                fill_col_n = '0;
`endif
              end
              CH_CR: begin
                cur_col_n = '0;
              end
              CH_BS: begin
                // No reverse wrap onto the previous row at column 0.
                if (cur_col_q != 6'd0) begin
                  cur_col_n = cur_col_q - 6'd1;
                  wr_en_n   = 1'b1;
                  wr_row_n  = cur_row_q;
                  wr_col_n  = cur_col_q - 6'd1;
                  wr_char_n = BLANK;
                end
              end
              CH_FF: begin
                cur_row_n  = '0;
                cur_col_n  = '0;
                state_n    = CLEAR_ALL;
                fill_row_n = '0;
                fill_col_n = '0;
              end
              default: begin
                // Unknown control or non-ASCII byte: consumed and dropped.
              end
            endcase
          end
        end
      end

      CLEAR_ALL: begin
        wr_en_n   = 1'b1;
        wr_row_n  = fill_row;
        wr_col_n  = fill_col;
        wr_char_n = BLANK;
        if (fill_col == LAST_COL) begin
          fill_col_n = '0;
          if (fill_row == LAST_ROW) begin
            fill_row_n = '0;
            state_n    = IDLE;
          end else begin
            fill_row_n = fill_row + 4'd1;
          end
        end else begin
          fill_col_n = fill_col + 6'd1;
        end
      end

`ifdef LINE_CLEAR_EN
      CLEAR_ROW: begin
        // Cursor already points at the new row; it is held while blanking.
        wr_en_n   = 1'b1;
        wr_row_n  = cur_row_q;
        wr_col_n  = fill_col;
        wr_char_n = BLANK;
        if (fill_col == LAST_COL) begin
          fill_col_n = '0;
          state_n    = IDLE;
        end else begin
          fill_col_n = fill_col + 6'd1;
        end
      end
`endif

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n  = (state_n != IDLE);
    ready_n = (state_n == IDLE);
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_row   = wr_row_q;
  assign bus.wr_col   = wr_col_q;
  assign bus.wr_char  = wr_char_q;
  assign bus.cur_row  = cur_row_q;
  assign bus.cur_col  = cur_col_q;
  assign bus.busy     = busy_q;
  assign bus.in_ready = ready_q;

endmodule

// File: tb/tb_text_write_scheduler.sv
// Self-checking bench for text_write_scheduler: table vectors, directed
// multi-cycle sequences, and random bytes against a screen-level write model.
module tb_text_write_scheduler;

  localparam int         ROWS  = 16;
  localparam int         COLS  = 64;
  localparam logic [7:0] BLANK = 8'h20;
`ifdef LINE_CLEAR_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  text_write_scheduler_if bus ();

  text_write_scheduler #(.ROWS(ROWS), .COLS(COLS), .BLANK(BLANK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [17:0] obs_q[$];
  logic [17:0] exp_q[$];

  int         m_row, m_col;
  bit         m_wr;
  int         m_wr_row, m_wr_col;
  logic [7:0] m_wr_char;

  typedef struct {
    logic [7:0] ch;
    bit         wr;
    int         wr_r;
    int         wr_c;
    logic [7:0] wr_ch;
    int         cr;
    int         cc;
  } vec_t;

  vec_t tv[13];

  // Every write the DUT issues, captured just after the edge that drives it.
  always @(posedge clk) begin
    #1;
    if (bus.wr_en === 1'b1) obs_q.push_back({bus.wr_row, bus.wr_col, bus.wr_char});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: screen-level effect of one accepted byte.
  function automatic void m_push(int r, int c, logic [7:0] ch);
    exp_q.push_back({4'(r), 6'(c), ch});
  endfunction

  function automatic void m_clear_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_push(r, c, BLANK);
  endfunction

  function automatic void m_newline();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    if (LC) for (int c = 0; c < COLS; c++) m_push(m_row, c, BLANK);
  endfunction

  function automatic void m_apply(logic [7:0] ch);
    m_wr = 1'b0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      m_wr = 1'b1; m_wr_row = m_row; m_wr_col = m_col; m_wr_char = ch;
      m_push(m_row, m_col, ch);
      m_col++;
      if (m_col == COLS) m_newline();
    end else if (ch == 8'h0A) begin
      m_newline();
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_wr = 1'b1; m_wr_row = m_row; m_wr_col = m_col; m_wr_char = BLANK;
        m_push(m_row, m_col, BLANK);
      end
    end else if (ch == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      m_clear_all();
    end
  endfunction

  // Handshake one byte; valid is raised even while not ready. Ends at the
  // falling edge after the accepting edge.
  task automatic send_raw(input logic [7:0] ch);
    int waited = 0;
    @(negedge clk);
    bus.in_char  = ch;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("ready_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_chk(input logic [7:0] ch);
    send_raw(ch);
    m_apply(ch);
    chk($sformatf("wr_en[%02h]", ch), bus.wr_en, m_wr);
    if (m_wr) begin
      chk($sformatf("wr_addr[%02h]", ch), {bus.wr_row, bus.wr_col}, {4'(m_wr_row), 6'(m_wr_col)});
      chk($sformatf("wr_char[%02h]", ch), bus.wr_char, m_wr_char);
    end
    chk($sformatf("cursor[%02h]", ch), {bus.cur_row, bus.cur_col}, {4'(m_row), 6'(m_col)});
  endtask

  task automatic count_to_ready(output int n);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic compare_queues(input string name);
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", name, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    logic [7:0] ch;

    // ch, wr, wr_row, wr_col, wr_char, cur_row, cur_col  (starting at (0,0))
    tv[0]  = '{8'h41, 1'b1, 0, 0, 8'h41, 0, 1};
    tv[1]  = '{8'h42, 1'b1, 0, 1, 8'h42, 0, 2};
    tv[2]  = '{8'h08, 1'b1, 0, 1, 8'h20, 0, 1};
    tv[3]  = '{8'h0D, 1'b0, 0, 0, 8'h00, 0, 0};
    tv[4]  = '{8'h08, 1'b0, 0, 0, 8'h00, 0, 0};
    tv[5]  = '{8'h07, 1'b0, 0, 0, 8'h00, 0, 0};
    tv[6]  = '{8'h80, 1'b0, 0, 0, 8'h00, 0, 0};
    tv[7]  = '{8'h7E, 1'b1, 0, 0, 8'h7E, 0, 1};
    tv[8]  = '{8'h1F, 1'b0, 0, 0, 8'h00, 0, 1};
    tv[9]  = '{8'h7F, 1'b0, 0, 0, 8'h00, 0, 1};
    tv[10] = '{8'h20, 1'b1, 0, 1, 8'h20, 0, 2};
    tv[11] = '{8'h78, 1'b1, 0, 2, 8'h78, 0, 3};
    tv[12] = '{8'h08, 1'b1, 0, 2, 8'h20, 0, 2};

    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en",    bus.wr_en,    0);
    chk("rst_wr_row",   bus.wr_row,   0);
    chk("rst_wr_col",   bus.wr_col,   0);
    chk("rst_wr_char",  bus.wr_char,  0);
    chk("rst_cur_row",  bus.cur_row,  0);
    chk("rst_cur_col",  bus.cur_col,  0);
    chk("rst_busy",     bus.busy,     1);
    chk("rst_in_ready", bus.in_ready, 0);
    obs_q.delete();
    reset = 1'b0;

    count_to_ready(n);
    chk("init_clear_cycles", n, 1024);
    chk("init_busy", bus.busy, 0);
    m_row = 0;
    m_col = 0;
    m_clear_all();
    compare_queues("init_clear");
    chk("init_cursor", {bus.cur_row, bus.cur_col}, 0);

    for (int i = 0; i < 13; i++) begin
      send_raw(tv[i].ch);
      m_apply(tv[i].ch);
      chk($sformatf("tv%0d_wr_en", i), bus.wr_en, tv[i].wr);
      if (tv[i].wr) begin
        chk($sformatf("tv%0d_wr_addr", i), {bus.wr_row, bus.wr_col}, {4'(tv[i].wr_r), 6'(tv[i].wr_c)});
        chk($sformatf("tv%0d_wr_char", i), bus.wr_char, tv[i].wr_ch);
      end
      chk($sformatf("tv%0d_cursor", i), {bus.cur_row, bus.cur_col}, {4'(tv[i].cr), 6'(tv[i].cc)});
      chk($sformatf("tv%0d_ready", i), bus.in_ready, 1);
    end
    compare_queues("table");

    // Back-to-back printable bytes, one per clock.
    send_chk(8'h0D);
    bus.in_char  = 8'h41;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_char = 8'h42;
    @(negedge clk);
    chk("b2b_first", {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_char}, {1'b1, 4'd0, 6'd0, 8'h41});
    chk("b2b_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second", {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_char}, {1'b1, 4'd0, 6'd1, 8'h42});
    m_apply(8'h41);
    m_apply(8'h42);
    chk("b2b_cursor", {bus.cur_row, bus.cur_col}, {4'd0, 6'd2});

    // Column wrap at (0,63).
    for (int i = 0; i < 61; i++) send_chk(8'h61 + 8'(i % 26));
    chk("pre_wrap_cursor", {bus.cur_row, bus.cur_col}, {4'd0, 6'd63});
    send_raw(8'h5A);
    m_apply(8'h5A);
    chk("wrap_write", {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_char}, {1'b1, 4'd0, 6'd63, 8'h5A});
    chk("wrap_cursor", {bus.cur_row, bus.cur_col}, {4'd1, 6'd0});
    chk("wrap_ready", bus.in_ready, LC ? 0 : 1);
    chk("wrap_busy", bus.busy, LC ? 1 : 0);
    count_to_ready(n);
    chk("wrap_clear_cycles", n, LC ? 64 : 0);
    compare_queues("wrap");

    // LF from the last row wraps to row 0.
    for (int i = 0; i < 14; i++) send_chk(8'h0A);
    for (int i = 0; i < 10; i++) send_chk(8'h30 + 8'(i));
    chk("pre_lf_cursor", {bus.cur_row, bus.cur_col}, {4'd15, 6'd10});
    send_raw(8'h0A);
    m_apply(8'h0A);
    chk("lf_no_write", bus.wr_en, 0);
    chk("lf_cursor", {bus.cur_row, bus.cur_col}, 0);
    count_to_ready(n);
    chk("lf_clear_cycles", n, LC ? 64 : 0);
    send_chk(8'h08);
    send_chk(8'h78);
    send_chk(8'h08);
    compare_queues("lf_bs");

    // FF with reset asserted at the 500th clear write.
    for (int i = 0; i < 5; i++) send_chk(8'h0A);
    for (int i = 0; i < 7; i++) send_chk(8'h4B);
    chk("pre_ff_cursor", {bus.cur_row, bus.cur_col}, {4'd5, 6'd7});
    compare_queues("pre_ff");
    send_raw(8'h0C);
    chk("ff_cursor", {bus.cur_row, bus.cur_col}, 0);
    chk("ff_status", {bus.wr_en, bus.busy, bus.in_ready}, 3'b010);
    n = 0;
    while (obs_q.size() < 500 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ff_500_writes", obs_q.size(), 500);
    reset = 1'b1;
    if (obs_q.size() >= 500) begin
      chk("ff_first_write", obs_q[0], {4'd0, 6'd0, BLANK});
      chk("ff_500th_write", obs_q[499], {4'd7, 6'd51, BLANK});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ff_rst_status", {bus.wr_en, bus.busy, bus.in_ready}, 3'b010);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    m_clear_all();
    count_to_ready(n);
    chk("restart_clear_cycles", n, 1024);
    compare_queues("restart_clear");
    chk("restart_cursor", {bus.cur_row, bus.cur_col}, 0);

    // Random byte stream against the model.
    for (int i = 0; i < 250; i++) begin
      n = $urandom_range(0, 99);
      if (n < 68)      ch = 8'($urandom_range(32, 126));
      else if (n < 78) ch = 8'h0A;
      else if (n < 84) ch = 8'h0D;
      else if (n < 93) ch = 8'h08;
      else if (n < 95) ch = 8'h0C;
      else             ch = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_chk(ch);
    end
    count_to_ready(n);
    chk("random_drain", bus.in_ready, 1);
    compare_queues("random");
    chk("random_cursor", {bus.cur_row, bus.cur_col}, {4'(m_row), 6'(m_col)});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
